// File: rtl/tick_pkg.sv
// Shared constants and types for the tick dispatcher and its per-channel counters.
package tick_pkg;

  localparam int NUM_CH   = 3;
  localparam int PEND_W   = 2;
  localparam int PEND_MAX = 2**PEND_W - 1;

  // Tick channel identities, in arbitration index order.
  typedef enum logic [1:0] {
    CH_SCRIPT = 2'd0,
    CH_GAME   = 2'd1,
    CH_BOSS   = 2'd2
  } ch_e;

  // Dispatcher handshake states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

endpackage

// File: rtl/tick_pending_ctr.sv
// Saturating up/down pending counter for one tick channel, with a sticky
// overrun flag raised when a tick arrives while the counter is already full.
module tick_pending_ctr #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  input  logic              clr_ovr,
  output logic [PEND_W-1:0] count,
  output logic              overrun
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] count_reg, count_next;
  logic              ovr_reg, ovr_next;
  logic              sat_hit;

  // Next count: simultaneous inc and dec cancel; a full counter drops the tick.
  always_comb begin
    count_next = count_reg;
    sat_hit    = 1'b0;
    if (inc && !dec) begin
      if (count_reg == CNT_MAX) begin
        sat_hit = 1'b1;
      end else begin
        count_next = count_reg + 1'b1;
      end
    end else if (dec && !inc && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
    end
    // A lost tick in the clearing cycle must still be reported.
    if (sat_hit) begin
      ovr_next = 1'b1;
    end else if (clr_ovr) begin
      ovr_next = 1'b0;
    end else begin
      ovr_next = ovr_reg;
    end
  end

  // Counter and overrun flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      ovr_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      ovr_reg   <= ovr_next;
    end
  end

  assign count   = count_reg;
  assign overrun = ovr_reg;

endmodule

// File: rtl/tick_dispatcher.sv
// Collects tick strobes into per-channel pending counts and issues one
// update request at a time to the game-update engine, round-robin.
module tick_dispatcher
  import tick_pkg::*;
#(
  parameter int NUM_CH = tick_pkg::NUM_CH,
  parameter int PEND_W = tick_pkg::PEND_W,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] tick_i,
  output logic              upd_req_o,
  output logic [CH_W-1:0]   upd_ch_o,
  input  logic              upd_ack_i,
  output logic [NUM_CH-1:0] pending_o,
  output logic [NUM_CH-1:0] overrun_o,
  input  logic              clr_overrun_i,
  output logic              busy_o
);

  state_e            state_reg, state_next;
  logic [CH_W-1:0]   ch_reg, ch_next;
  logic [CH_W-1:0]   last_reg, last_next;
  logic              accept;
  logic              grant_found;
  logic [CH_W-1:0]   grant_ch;
  logic [CH_W-1:0]   rr_idx [NUM_CH];
  logic [PEND_W-1:0] count [NUM_CH];

  assign accept = upd_req_o && upd_ack_i;

  // One counter per channel; only the granted channel sees the acceptance.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    tick_pending_ctr #(
      .PEND_W(PEND_W)
    ) u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (tick_i[gi]),
      .dec     (accept && (ch_reg == CH_W'(gi))),
      .clr_ovr (clr_overrun_i),
      .count   (count[gi]),
      .overrun (overrun_o[gi])
    );
    assign pending_o[gi] = |count[gi];
    // Search order: the channel after the last granted one comes first.
    assign rr_idx[gi] = CH_W'((int'(last_reg) + gi + 1) % NUM_CH);
  end

  // Round-robin pick of the first pending channel in search order.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!grant_found && pending_o[rr_idx[k]]) begin
        grant_found = 1'b1;
        grant_ch    = rr_idx[k];
      end
    end
  end

  // State, granted channel and last-granted pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ch_reg    <= '0;
      last_reg  <= CH_W'(NUM_CH - 1);
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
      last_reg  <= last_next;
    end
  end

  // Next state: grant from IDLE, return to IDLE on acceptance.
  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    last_next  = last_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_found) begin
          state_next = ST_REQ;
          ch_next    = grant_ch;
        end
      end
      ST_REQ: begin
        if (upd_ack_i) begin
          state_next = ST_IDLE;
          last_next  = ch_reg;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded straight from registered state.
  always_comb begin
    upd_req_o = (state_reg == ST_REQ);
    busy_o    = (state_reg == ST_REQ);
    upd_ch_o  = ch_reg;
  end

endmodule

// File: doc/tick_dispatcher.md
TICK_DISPATCHER -- requirements
Module: tick_dispatcher

Interface
REQ-001 Parameter NUM_CH, default 3, SHALL set the number of tick channels (0 script, 1 game, 2 boss).
REQ-002 Parameter PEND_W, default 2, SHALL set the pending-counter width; PEND_MAX = 2**PEND_W-1 = 3.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port tick_i  input  NUM_CH  SHALL carry the one-cycle tick strobes from the clock divider, bit n = channel n.
REQ-006 Port upd_req_o  output  1  SHALL request one update of channel upd_ch_o from the game-update engine.
REQ-007 Port upd_ch_o  output  2  SHALL give the granted channel index, stable while upd_req_o=1.
REQ-008 Port upd_ack_i  input  1  SHALL signal acceptance of the current request.
REQ-009 Port pending_o  output  NUM_CH  SHALL be 1 per channel whose pending count is non-zero.
REQ-010 Port overrun_o  output  NUM_CH  SHALL be sticky per-channel tick-loss flags.
REQ-011 Port clr_overrun_i  input  1  SHALL clear all overrun_o bits.
REQ-012 Port busy_o  output  1  SHALL equal 1 while in state REQ.

Function
REQ-013 Each channel SHALL hold a PEND_W-bit pending count; tick_i[n]=1 increments it next edge.
REQ-014 Acceptance (upd_req_o=1 and upd_ack_i=1) SHALL decrement the granted channel's count next edge.
REQ-015 Tick and acceptance on the same channel in the same cycle SHALL leave the count unchanged.
REQ-016 Tick on a channel at PEND_MAX without same-cycle acceptance SHALL hold the count at PEND_MAX and set overrun_o[n] next edge.
REQ-017 clr_overrun_i SHALL clear all overrun bits next edge; a new overrun in the same cycle SHALL win for its bit.
REQ-018 FSM SHALL have states IDLE and REQ; upd_req_o SHALL be registered, 1 only in REQ.
REQ-019 IDLE -> REQ when any count is non-zero; grant SHALL be round-robin, searching from (last granted+1) mod NUM_CH.
REQ-020 upd_ch_o SHALL be latched on IDLE -> REQ and held until return to IDLE.
REQ-021 REQ -> IDLE on acceptance; upd_req_o SHALL be 0 for at least one cycle between requests.
REQ-022 upd_ack_i while upd_req_o=0 SHALL be ignored.
REQ-023 Latency: tick at edge N SHALL give pending_o at N+1 and upd_req_o at N+2 when IDLE.
REQ-024 After acceptance at edge M, next upd_req_o SHALL rise no earlier than M+2.
REQ-025 Last-granted pointer SHALL update only on acceptance.

Reset
REQ-026 rst_n=0 SHALL immediately force: counts 0, pending_o 0, overrun_o 0, upd_req_o 0, upd_ch_o 0, busy_o 0, state IDLE, last-granted = NUM_CH-1.
REQ-027 Reset mid-request SHALL drop upd_req_o without waiting for ack; pending ticks are discarded.
REQ-028 First edge after deassertion SHALL sample tick_i normally.

Structure
REQ-029 Shared package tick_pkg SHALL hold NUM_CH, PEND_W, channel enum ch_e (CH_SCRIPT, CH_GAME, CH_BOSS) and FSM state enum.
REQ-030 One sub-module tick_pending_ctr (saturating up/down counter with overrun output) SHALL be instantiated per channel.

Verification
REQ-031 Single tick_i=3'b010, ack 1 cycle after req -> req at N+2 with upd_ch_o=1, pending_o returns to 0, overrun_o=0.
REQ-032 tick_i=3'b111 once, ack immediate each time -> grants in order 0,1,2 with 1 idle cycle between requests.
REQ-033 Four game ticks, ack held 0 -> count saturates at 3, overrun_o=3'b010; clr_overrun_i pulse -> 3'b000.
REQ-034 Tick on granted channel in same cycle as ack -> count unchanged, new req for same channel follows.
REQ-035 rst_n pulsed low while upd_req_o=1 -> all outputs 0 asynchronously; no request after release until a new tick.
REQ-036 Ack asserted while upd_req_o=0 -> no state, count or pointer change.
